// File: rtl/z80_mmu_paged.sv
// Paged memory mapper for a Z80: page table programmed over I/O behind a key-sequence lock,
// combinational bank/chip-select decode and a sticky write-protect fault.
module z80_mmu_paged #(
  parameter int          PAGE_BITS = 3,
  parameter int          BANK_W    = 6,
  parameter logic [7:0]  MAP_PORT  = 8'hD8,
  parameter logic [7:0]  CTRL_PORT = 8'hD0,
  parameter logic [7:0]  KEY       = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              iorq_n,
  input  logic              mreq_n,
  input  logic [15:0]       addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic [BANK_W-1:0] bank,
  output logic              rom_sel_n,
  output logic              ram_sel_n,
  output logic              wp_fault
);

  // state     | meaning
  // LOCKED    | table writes ignored, waiting for KEY
  // ARMED     | KEY seen, waiting for ~KEY
  // UNLOCKED  | table writes accepted; 8'h00 on CTRL relocks
  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    ARMED    = 2'd1,
    UNLOCKED = 2'd2
  } lock_state_e;

  localparam int         NPAGE      = 1 << PAGE_BITS;
  localparam logic [7:0] BANK_MASK  = 8'((1 << BANK_W) - 1);
  localparam logic [7:0] ENTRY_MASK = 8'hC0 | BANK_MASK;

  lock_state_e state_q;
  logic [7:0]  table_q [NPAGE];
  logic        wp_fault_q, wp_fault_d;

  logic [1:0]  rd_sync_q, wr_sync_q, iorq_sync_q, mreq_sync_q;
  logic        rd_prev_q, wr_prev_q;
  logic        rd_ev, wr_ev, io_wr_ev, io_rd_ev, mem_wr_ev;

  logic                 map_hit, ctrl_hit;
  logic [PAGE_BITS-1:0] io_idx, mem_idx;
  logic [7:0]           mem_entry;
  logic                 unused_addr;

  assign unused_addr = ^addr[15-PAGE_BITS:8];

  // Strobe chains reset to the asserted level so an access already in flight when
  // reset releases never produces a falling edge and is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sync_q   <= 2'b00;
      wr_sync_q   <= 2'b00;
      rd_prev_q   <= 1'b0;
      wr_prev_q   <= 1'b0;
      iorq_sync_q <= 2'b11;
      mreq_sync_q <= 2'b11;
    end else begin
      rd_sync_q   <= {rd_sync_q[0], rd_n};
      wr_sync_q   <= {wr_sync_q[0], wr_n};
      rd_prev_q   <= rd_sync_q[1];
      wr_prev_q   <= wr_sync_q[1];
      iorq_sync_q <= {iorq_sync_q[0], iorq_n};
      mreq_sync_q <= {mreq_sync_q[0], mreq_n};
    end
  end

  assign rd_ev     = rd_prev_q & ~rd_sync_q[1];
  assign wr_ev     = wr_prev_q & ~wr_sync_q[1];
  assign io_wr_ev  = wr_ev & ~iorq_sync_q[1];
  assign io_rd_ev  = rd_ev & ~iorq_sync_q[1];
  assign mem_wr_ev = wr_ev & ~mreq_sync_q[1];

  assign map_hit  = (addr[7:PAGE_BITS] == MAP_PORT[7:PAGE_BITS]);
  assign ctrl_hit = (addr[7:0] == CTRL_PORT);
  assign io_idx   = addr[PAGE_BITS-1:0];
  assign mem_idx  = addr[15 -: PAGE_BITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= UNLOCKED;
    end else if (io_wr_ev && ctrl_hit) begin
      case (state_q)
        LOCKED:   state_q <= (data_in == KEY) ? ARMED : LOCKED;
        ARMED:    state_q <= (data_in == ~KEY) ? UNLOCKED : LOCKED;
        UNLOCKED: state_q <= (data_in == 8'h00) ? LOCKED : UNLOCKED;
        default:  state_q <= LOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPAGE; i++) begin
        table_q[i] <= (i == 0) ? 8'h40 : (8'(i) & BANK_MASK);
      end
    end else if (io_wr_ev && map_hit && state_q == UNLOCKED) begin
      table_q[io_idx] <= data_in & ENTRY_MASK;
    end
  end

  assign mem_entry = table_q[mem_idx];

  // A new fault takes priority over the clear from a status read.
  always_comb begin
    wp_fault_d = wp_fault_q;
    if (io_rd_ev && ctrl_hit) wp_fault_d = 1'b0;
    if (mem_wr_ev && mem_entry[7]) wp_fault_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wp_fault_q <= 1'b0;
    else       wp_fault_q <= wp_fault_d;
  end

  assign wp_fault = wp_fault_q;

  always_comb begin
    data_out = 8'h00;
    data_oe  = 1'b0;
    if (!iorq_n && !rd_n) begin
      if (map_hit) begin
        data_oe  = 1'b1;
        data_out = table_q[io_idx];
      end else if (ctrl_hit) begin
        data_oe  = 1'b1;
        data_out = {wp_fault_q, 5'b00000, state_q};
      end
    end
  end

  assign bank      = mem_entry[BANK_W-1:0];
  assign rom_sel_n = mreq_n | ~mem_entry[6];
  assign ram_sel_n = mreq_n | mem_entry[6] | (mem_entry[7] & ~wr_n);

endmodule

// File: tb/tb_z80_mmu_paged.sv
// Directed bench for z80_mmu_paged: table readback, lock sequence, decode,
// write-protect fault and asynchronous reset during an access.
module tb_z80_mmu_paged;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_n = 1'b1, wr_n = 1'b1, iorq_n = 1'b1, mreq_n = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [5:0]  bank;
  logic        rom_sel_n, ram_sel_n, wp_fault;

  int n_vec = 0;
  int n_err = 0;

  z80_mmu_paged dut (
    .clk       (clk),
    .reset     (reset),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .iorq_n    (iorq_n),
    .mreq_n    (mreq_n),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .bank      (bank),
    .rom_sel_n (rom_sel_n),
    .ram_sel_n (ram_sel_n),
    .wp_fault  (wp_fault)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic io_wr(input logic [7:0] port, input logic [7:0] val);
    @(negedge clk);
    addr = {8'h00, port}; data_in = val; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (5) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic io_rd(input logic [7:0] port, output logic [7:0] d, output logic oe);
    @(negedge clk);
    addr = {8'h00, port}; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    d = data_out; oe = data_oe;
    repeat (5) @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic mem_acc(input logic [15:0] a, input logic is_wr,
                         output logic rom_n, output logic ram_n, output logic [5:0] bk);
    @(negedge clk);
    addr = a; mreq_n = 1'b0;
    if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
    #1;
    rom_n = rom_sel_n; ram_n = ram_sel_n; bk = bank;
    repeat (5) @(negedge clk);
    mreq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  logic [7:0] rd_d;
  logic       rd_oe;
  logic       rom_n, ram_n;
  logic [5:0] bk;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk_val("rst_data_oe", 16'(data_oe), 16'h0);
    chk_val("rst_data_out", 16'(data_out), 16'h00);
    chk_val("rst_wp_fault", 16'(wp_fault), 16'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      io_rd(8'hD8 + 8'(i), rd_d, rd_oe);
      chk_val($sformatf("rst_entry%0d", i), 16'(rd_d), (i == 0) ? 16'h40 : 16'(i));
      chk_val($sformatf("rst_entry%0d_oe", i), 16'(rd_oe), 16'h1);
    end
    io_rd(8'hD0, rd_d, rd_oe);
    chk_val("rst_ctrl", 16'(rd_d), 16'h02);
    mem_acc(16'h0000, 1'b0, rom_n, ram_n, bk);
    chk_val("p0_rom_sel_n", 16'(rom_n), 16'h0);
    chk_val("p0_ram_sel_n", 16'(ram_n), 16'h1);
    chk_val("p0_bank", 16'(bk), 16'h00);

    io_wr(8'hD0, 8'h00);
    io_rd(8'hD0, rd_d, rd_oe);
    chk_val("locked_ctrl", 16'(rd_d), 16'h00);
    io_wr(8'hDB, 8'h15);
    io_rd(8'hDB, rd_d, rd_oe);
    chk_val("locked_wr_ignored", 16'(rd_d), 16'h03);

    io_wr(8'hD0, 8'hA5);
    io_rd(8'hD0, rd_d, rd_oe);
    chk_val("armed_ctrl", 16'(rd_d), 16'h01);
    io_wr(8'hD0, 8'h5A);
    io_rd(8'hD0, rd_d, rd_oe);
    chk_val("unlock_ctrl", 16'(rd_d), 16'h02);
    io_wr(8'hDB, 8'h15);
    io_rd(8'hDB, rd_d, rd_oe);
    chk_val("entry3_new", 16'(rd_d), 16'h15);
    mem_acc(16'h6000, 1'b0, rom_n, ram_n, bk);
    chk_val("p3_bank", 16'(bk), 16'd21);
    chk_val("p3_ram_sel_n", 16'(ram_n), 16'h0);
    chk_val("p3_rom_sel_n", 16'(rom_n), 16'h1);

    io_wr(8'hD0, 8'h00);
    io_wr(8'hD0, 8'hA5);
    io_wr(8'hD0, 8'h11);
    io_rd(8'hD0, rd_d, rd_oe);
    chk_val("bad_key_ctrl", 16'(rd_d), 16'h00);
    io_wr(8'hD0, 8'hA5);
    io_wr(8'hD0, 8'h5A);
    io_wr(8'hD0, 8'h37);
    io_rd(8'hD0, rd_d, rd_oe);
    chk_val("unlocked_hold", 16'(rd_d), 16'h02);

    io_rd(8'h10, rd_d, rd_oe);
    chk_val("oe_far_port", 16'(rd_oe), 16'h0);
    io_rd(8'hD7, rd_d, rd_oe);
    chk_val("oe_below_map", 16'(rd_oe), 16'h0);
    io_rd(8'hD1, rd_d, rd_oe);
    chk_val("oe_after_ctrl", 16'(rd_oe), 16'h0);

    io_wr(8'hDD, 8'h6A);
    mem_acc(16'hA000, 1'b0, rom_n, ram_n, bk);
    chk_val("p5_rom_sel_n", 16'(rom_n), 16'h0);
    chk_val("p5_ram_sel_n", 16'(ram_n), 16'h1);
    chk_val("p5_bank", 16'(bk), 16'h2A);
    mem_acc(16'hA000, 1'b1, rom_n, ram_n, bk);
    chk_val("p5_wr_ram_sel_n", 16'(ram_n), 16'h1);
    chk_val("p5_wr_no_fault", 16'(wp_fault), 16'h0);

    io_wr(8'hDA, 8'h82);
    mem_acc(16'h4000, 1'b1, rom_n, ram_n, bk);
    chk_val("wp_wr_ram_sel_n", 16'(ram_n), 16'h1);
    chk_val("wp_fault_set", 16'(wp_fault), 16'h1);
    mem_acc(16'h4000, 1'b0, rom_n, ram_n, bk);
    chk_val("wp_rd_ram_sel_n", 16'(ram_n), 16'h0);
    chk_val("wp_rd_bank", 16'(bk), 16'h02);
    io_rd(8'hD0, rd_d, rd_oe);
    chk_val("fault_ctrl", 16'(rd_d), 16'h82);
    chk_val("fault_cleared", 16'(wp_fault), 16'h0);

    mem_acc(16'h4000, 1'b1, rom_n, ram_n, bk);
    chk_val("wp_fault_again", 16'(wp_fault), 16'h1);
    @(negedge clk);
    addr = 16'h00D9; data_in = 8'h3F; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    repeat (4) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_val("rstmid_fault", 16'(wp_fault), 16'h0);
    io_rd(8'hD9, rd_d, rd_oe);
    chk_val("rstmid_entry1", 16'(rd_d), 16'h01);
    io_rd(8'hDA, rd_d, rd_oe);
    chk_val("rstmid_entry2", 16'(rd_d), 16'h02);
    io_rd(8'hD0, rd_d, rd_oe);
    chk_val("rstmid_ctrl", 16'(rd_d), 16'h02);

    io_wr(8'hD0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    io_rd(8'hD0, rd_d, rd_oe);
    chk_val("rst_from_locked", 16'(rd_d), 16'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
